// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_ctrl_pkg;

    typedef enum logic [1:0] {
        LOAD,
        FILL,
        RUN,
        ERR
    } boot_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int IMEM_DEPTH     = 64;

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Byte-stream loader handshake into the boot controller.
interface imem_boot_ctrl_if;

    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;

    modport master (
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready
    );

endinterface

// File: rtl/imem_boot_ctrl_byte_packer.sv
// Packs a little-endian byte stream into N-bit words.
module byte_packer
    import imem_ctrl_pkg::*;
#(
    parameter int N = 8 * BYTES_PER_WORD
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         word_valid,
    output logic [N-1:0] word,
    output logic         partial
);

    localparam int BPW = N / 8;
    localparam int CW  = $clog2(BPW);
    localparam logic [CW-1:0] LAST = CW'(BPW - 1);

    logic [CW-1:0] cnt;
    logic [N-9:0]  shreg;

    assign word_valid = in_valid && (cnt == LAST);
    assign word       = {in_data, shreg};
    assign partial    = (cnt != '0);

    // newest byte enters at the top so the first byte ends up in bits 7:0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (clear) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (in_valid) begin
            cnt   <= word_valid ? '0 : cnt + 1'b1;
            shreg <= {in_data, shreg[N-9:8]};
        end
    end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot loader and fetch mux for the writable instruction memory.
module imem_boot_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int N  = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    imem_boot_ctrl_if.slave ld,
    input  logic          boot_req,
    input  logic [AW-1:0] cpu_addr,
    output logic [N-1:0]  cpu_q,
    output logic          cpu_run,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_rdata,
    output logic [AW:0]   loaded_words,
    output logic          err
);

    boot_state_t   state, state_nx;
    logic [AW:0]   wptr;
    logic          full;
    logic          accept;
    logic          rearm;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [N-1:0]  wdata_q;
    logic          pk_valid;
    logic          pk_clear;
    logic          word_valid;
    logic          partial;
    logic [N-1:0]  word;

    // wptr carries one extra bit so "all words written" is wptr[AW]
    assign full     = wptr[AW];
    assign accept   = (state == LOAD) && ld.ld_valid;
    assign rearm    = boot_req && ((state == RUN) || (state == ERR));
    assign pk_valid = accept && !full;
    assign pk_clear = (state != LOAD) && (partial || boot_req);

    byte_packer #(
        .N (N)
    ) u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (pk_clear),
        .in_valid   (pk_valid),
        .in_data    (ld.ld_data),
        .word_valid (word_valid),
        .word       (word),
        .partial    (partial)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= LOAD;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        ld.ld_ready = 1'b0;
        cpu_run     = 1'b0;
        err         = 1'b0;
        unique case (state)
            LOAD: begin
                ld.ld_ready = 1'b1;
                if (accept) begin
                    if (full)
                        state_nx = ERR;
                    else if (ld.ld_last)
                        state_nx = word_valid ? FILL : ERR;
                end
            end
            FILL: begin
                if (full) state_nx = RUN;
            end
            RUN: begin
                cpu_run = 1'b1;
                if (boot_req) state_nx = LOAD;
            end
            ERR: begin
                err = 1'b1;
                if (boot_req) state_nx = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr         <= '0;
            loaded_words <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            we_q <= 1'b0;
            if (pk_valid && word_valid) begin
                we_q         <= 1'b1;
                addr_q       <= wptr[AW-1:0];
                wdata_q      <= word;
                wptr         <= wptr + 1'b1;
                loaded_words <= loaded_words + 1'b1;
            end else if (state == FILL && !full) begin
                we_q    <= 1'b1;
                addr_q  <= wptr[AW-1:0];
                wdata_q <= '0;
                wptr    <= wptr + 1'b1;
            end else if (rearm) begin
                wptr         <= '0;
                loaded_words <= '0;
                addr_q       <= '0;
                wdata_q      <= '0;
            end
        end
    end

    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;
    assign mem_addr  = (state == RUN) ? cpu_addr : addr_q;
    assign cpu_q     = (state == RUN) ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed self-checking bench for imem_boot_ctrl with a behavioural RAM.
module tb_imem_boot_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        boot_req;
    logic [5:0]  cpu_addr;
    logic [31:0] cpu_q;
    logic        cpu_run;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [6:0]  loaded_words;
    logic        err;
    logic        wipe;

    logic [31:0] mem [64];
    int          wr_cnt [64];
    logic [31:0] exp_mem [64];

    int n_cmp = 0;
    int n_bad = 0;
    int c;

    imem_boot_ctrl_if ld ();

    imem_boot_ctrl #(
        .N  (32),
        .AW (6)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ld           (ld),
        .boot_req     (boot_req),
        .cpu_addr     (cpu_addr),
        .cpu_q        (cpu_q),
        .cpu_run      (cpu_run),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .loaded_words (loaded_words),
        .err          (err)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (wipe) begin
            for (int i = 0; i < 64; i++) begin
                mem[i]    <= 32'hdeadbeef;
                wr_cnt[i] <= 0;
            end
        end else if (mem_we) begin
            mem[mem_addr]    <= mem_wdata;
            wr_cnt[mem_addr] <= wr_cnt[mem_addr] + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        ld.ld_valid = 1'b1;
        ld.ld_data  = b;
        ld.ld_last  = last;
        @(negedge clk);
        ld.ld_valid = 1'b0;
        ld.ld_last  = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rearm();
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
    endtask

    task automatic do_wipe();
        wipe = 1'b1;
        @(negedge clk);
        wipe = 1'b0;
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (!cpu_run && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 64; i++) exp_mem[i] = 32'h0;
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        int wbad = 0;
        for (int i = 0; i < 64; i++) begin
            if (mem[i] !== exp_mem[i]) bad++;
            if (wr_cnt[i] != 1) wbad++;
        end
        chk({tag, "_data"}, bad, 0);
        chk({tag, "_wrcnt"}, wbad, 0);
    endtask

    function automatic logic [7:0] fb(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    logic [7:0] short_img [8] = '{8'h01, 8'h00, 8'h00, 8'hf8,
                                   8'h02, 8'h80, 8'h00, 8'hf8};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        boot_req    = 1'b0;
        cpu_addr    = 6'd0;
        ld.ld_valid = 1'b0;
        ld.ld_data  = 8'h0;
        ld.ld_last  = 1'b0;
        wipe        = 1'b1;
        cyc(2);
        wipe = 1'b0;

        chk("rst_ready", ld.ld_ready, 1);
        chk("rst_run", cpu_run, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_loaded", loaded_words, 0);
        chk("rst_err", err, 0);
        chk("rst_cpu_q", cpu_q, 0);
        reset_n = 1'b1;
        cyc(1);

        // short image, back-to-back
        for (int i = 0; i < 4; i++) send(short_img[i], 1'b0);
        chk("w0_we", mem_we, 1);
        chk("w0_addr", mem_addr, 0);
        chk("w0_data", mem_wdata, 32'hf8000001);
        chk("w0_ready", ld.ld_ready, 1);
        chk("w0_loaded", loaded_words, 1);
        for (int i = 4; i < 8; i++) send(short_img[i], i == 7);
        chk("w1_we", mem_we, 1);
        chk("w1_addr", mem_addr, 1);
        chk("w1_data", mem_wdata, 32'hf8008002);
        chk("fill_ready", ld.ld_ready, 0);
        wait_run(c);
        chk("short_run_lat", c, 63);
        chk("short_loaded", loaded_words, 2);
        clear_exp();
        exp_mem[0] = 32'hf8000001;
        exp_mem[1] = 32'hf8008002;
        check_mem("short");
        cpu_addr = 6'd1;
        #1;
        chk("fetch1", cpu_q, 32'hf8008002);
        chk("fetch1_addr", mem_addr, 1);
        chk("run_we", mem_we, 0);
        cpu_addr = 6'd0;
        #1;
        chk("fetch0", cpu_q, 32'hf8000001);

        // leave RUN, then gapped stream with ignored boot_req pulses
        do_wipe();
        rearm();
        chk("rearm_run", cpu_run, 0);
        chk("rearm_ready", ld.ld_ready, 1);
        chk("rearm_loaded", loaded_words, 0);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) begin
                boot_req = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            boot_req = 1'b0;
            send(short_img[i], i == 7);
        end
        wait_run(c);
        chk("gap_run_lat", c, 63);
        chk("gap_loaded", loaded_words, 2);
        check_mem("gap");

        // full 64-word image
        do_wipe();
        rearm();
        for (int i = 0; i < 256; i++) send(fb(i), i == 255);
        chk("full_we", mem_we, 1);
        chk("full_addr", mem_addr, 63);
        chk("full_run0", cpu_run, 0);
        cyc(1);
        chk("full_run1", cpu_run, 1);
        chk("full_loaded", loaded_words, 64);
        for (int w = 0; w < 64; w++)
            exp_mem[w] = {fb(4*w+3), fb(4*w+2), fb(4*w+1), fb(4*w)};
        check_mem("full");

        // overflow: 257th byte without ld_last
        do_wipe();
        rearm();
        for (int i = 0; i < 256; i++) send(fb(i), 1'b0);
        chk("ovf_loaded", loaded_words, 64);
        chk("ovf_pre_err", err, 0);
        send(8'haa, 1'b0);
        chk("ovf_err", err, 1);
        chk("ovf_ready", ld.ld_ready, 0);
        cyc(3);
        chk("ovf_run", cpu_run, 0);

        // misaligned end on byte 3 of word 5
        rearm();
        do_wipe();
        for (int i = 0; i < 20; i++) send(fb(i), 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        chk("mis_err", err, 1);
        cyc(2);
        chk("mis_no_w5", wr_cnt[5], 0);
        chk("mis_w4", wr_cnt[4], 1);
        chk("mis_loaded", loaded_words, 5);
        chk("mis_we", mem_we, 0);
        rearm();
        chk("mis_clr_err", err, 0);
        chk("mis_clr_ready", ld.ld_ready, 1);
        chk("mis_clr_loaded", loaded_words, 0);

        // reset in the middle of FILL
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        cyc(10);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mrst_we", mem_we, 0);
        chk("mrst_addr", mem_addr, 0);
        chk("mrst_wdata", mem_wdata, 0);
        chk("mrst_ready", ld.ld_ready, 1);
        chk("mrst_loaded", loaded_words, 0);
        chk("mrst_run", cpu_run, 0);
        chk("mrst_err", err, 0);
        chk("mrst_cpu_q", cpu_q, 0);
        @(negedge clk);
        reset_n = 1'b1;
        do_wipe();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        wait_run(c);
        chk("one_run_lat", c, 64);
        chk("one_loaded", loaded_words, 1);
        clear_exp();
        exp_mem[0] = 32'h44332211;
        check_mem("one");
        cpu_addr = 6'd0;
        #1;
        chk("one_fetch", cpu_q, 32'h44332211);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
